otter_regfile_sb: RTL



---
 rtl/otter_rf_pkg.sv | 38 +++
 rtl/otter_rf_scoreboard.sv | 55 +++++
 rtl/otter_regfile_sb.sv | 123 ++++++++++++
 3 files changed

// File: rtl/otter_rf_pkg.sv
// otter_rf_pkg: shared constants, types and the write-port hit helper for the
// OTTER register file and its busy scoreboard.
//   RF_XLEN / RF_NUM_REGS / RF_AW : default data width, register count, address width
//   ZERO_REG                      : hardwired-zero register index
//   MAX_AW / MAX_WR               : lane widths used by wr_hit (callers zero-pad into them)
//   wr_hit()                      : per-write-port match vector for one register address
package otter_rf_pkg;

    localparam int unsigned RF_XLEN     = 32;
    localparam int unsigned RF_NUM_REGS = 32;
    localparam int unsigned RF_AW       = $clog2(RF_NUM_REGS);
    localparam int unsigned ZERO_REG    = 0;

    // Fixed lane geometry so one helper serves every parameterisation.
    localparam int unsigned MAX_AW = 8;
    localparam int unsigned MAX_WR = 2;

    typedef logic [RF_AW-1:0]   rf_addr_t;
    typedef logic [RF_XLEN-1:0] rf_data_t;

    // Bit j is set when write port j is enabled and targets addr. Address 0 never
    // hits, so neither bypass nor scoreboard ever reacts to writes of x0.
    // Unused upper lanes must be passed in with wr_en cleared.
    function automatic logic [MAX_WR-1:0] wr_hit(
        input logic [MAX_AW-1:0]        addr,
        input logic [MAX_WR-1:0]        wr_en,
        input logic [MAX_WR*MAX_AW-1:0] wr_addr
    );
        logic [MAX_WR-1:0] hit;
        hit = '0;
        for (int j = 0; j < int'(MAX_WR); j++) begin
            hit[j] = wr_en[j] && (addr != MAX_AW'(ZERO_REG))
                     && (wr_addr[j*MAX_AW +: MAX_AW] == addr);
        end
        return hit;
    endfunction

endpackage

// File: rtl/otter_rf_scoreboard.sv
// otter_rf_scoreboard: per-register busy bits for decode-stage hazard detection.
//   clock, reset_n : clock, asynchronous active-low reset (clears all busy bits)
//   alloc_valid    : issue of an instruction writing alloc_addr (sets its bit)
//   alloc_addr     : destination register being issued
//   flush          : clear every busy bit (overrides a same-cycle alloc)
//   wr_en, wr_addr : writeback ports, zero-padded to MAX_WR lanes of MAX_AW bits
//   busy_vec       : current busy bits, bit 0 always 0
module otter_rf_scoreboard
    import otter_rf_pkg::*;
#(
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     alloc_valid,
    input  logic [AW-1:0]            alloc_addr,
    input  logic                     flush,
    input  logic [MAX_WR-1:0]        wr_en,
    input  logic [MAX_WR*MAX_AW-1:0] wr_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [MAX_WR-1:0]   hit;

    // Priority: flush, then alloc (newer producer owns the register), then writeback.
    always_comb begin
        busy_d = busy_q;
        hit    = '0;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            hit = wr_hit(MAX_AW'(r), wr_en, wr_addr);
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (alloc_valid && (alloc_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (|hit) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/otter_regfile_sb.sv
// otter_regfile_sb: multi-ported OTTER integer register file with same-cycle
// write-to-read bypass and an integrated busy scoreboard.
//   clock, reset_n         : clock, asynchronous active-low reset (data and busy cleared)
//   rd_addr / rd_data      : NUM_RD packed read ports, combinational
//   rd_busy                : per read port, register has an outstanding producer
//   alloc_valid/alloc_addr : issue-time destination allocation
//   wr_en/wr_addr/wr_data  : NUM_WR packed write ports, higher index wins on collision
//   flush                  : clear all busy bits, contents untouched
//   busy_vec               : full scoreboard, bit 0 always 0
module otter_regfile_sb
    import otter_rf_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   alloc_valid,
    input  logic [AW-1:0]          alloc_addr,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   flush,
    output logic [NUM_REGS-1:0]    busy_vec
);

    // Write ports repacked into the fixed lane layout expected by wr_hit.
    logic [MAX_WR-1:0]        wr_en_pk;
    logic [MAX_WR*MAX_AW-1:0] wr_addr_pk;
    logic [MAX_WR*XLEN-1:0]   wr_data_pk;

    always_comb begin
        wr_en_pk   = '0;
        wr_addr_pk = '0;
        wr_data_pk = '0;
        for (int j = 0; j < int'(NUM_WR); j++) begin
            wr_en_pk[j]                     = wr_en[j];
            wr_addr_pk[j*MAX_AW +: MAX_AW]  = MAX_AW'(wr_addr[j*AW +: AW]);
            wr_data_pk[j*XLEN +: XLEN]      = wr_data[j*XLEN +: XLEN];
        end
    end

    // Data array and write decode.
    logic [XLEN-1:0] rf_q [NUM_REGS];
    logic [XLEN-1:0] rf_d [NUM_REGS];

    always_comb begin
        rf_d = rf_q;
        // Ascending port order so the highest-indexed colliding port lands last.
        for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
                rf_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
        rf_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                rf_q[r] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Read ports with optional bypass.
    logic [AW-1:0]     ra;
    logic [MAX_WR-1:0] hit;
    logic [XLEN-1:0]   data;
    logic              bypass_hit;

    always_comb begin
        rd_data    = '0;
        rd_busy    = '0;
        ra         = '0;
        hit        = '0;
        data       = '0;
        bypass_hit = 1'b0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            ra         = rd_addr[i*AW +: AW];
            hit        = wr_hit(MAX_AW'(ra), wr_en_pk, wr_addr_pk);
            data       = rf_q[ra];
            bypass_hit = 1'b0;
            if (BYPASS != 0) begin
                for (int j = 0; j < int'(MAX_WR); j++) begin
                    if (hit[j]) begin
                        data       = wr_data_pk[j*XLEN +: XLEN];
                        bypass_hit = 1'b1;
                    end
                end
            end
            // Stored data is already zero in reset; this masks the bypass path too.
            if (!reset_n) begin
                data = '0;
            end
            rd_data[i*XLEN +: XLEN] = data;
            rd_busy[i]              = busy_vec[ra] & ~bypass_hit;
        end
    end

    otter_rf_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .wr_en       (wr_en_pk),
        .wr_addr     (wr_addr_pk),
        .busy_vec    (busy_vec)
    );

endmodule
